// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// NOP fill value and default datapath widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_t;

  // A NOP is the all-zeros word; replicate this bit to the needed width.
  localparam logic NOP_FILL = 1'b0;

  localparam int INSTR_W_DEF = 32;
  localparam int PC_W_DEF    = 22;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  // count up on inc, stop at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (inc && !w_at_max) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying instruction + PC.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hlt,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{NOP_FILL}};
  localparam logic [PC_W-1:0]    NOP_PC    = {PC_W{NOP_FILL}};

  pipe_state_t        r_state;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;

  logic w_out_valid;
  logic w_in_ready;
  logic w_accept;
  logic w_release;
  logic w_stall;

  assign w_out_valid = (r_state != PIPE_EMPTY) & ~hlt;
  assign w_release   = w_out_valid & out_ready;
  assign w_accept    = in_valid & w_in_ready & ~hlt & ~flush;
  assign w_stall     = w_out_valid & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic               r_in_ready;

  // in_ready comes from a flop; hlt only masks it, out_ready never reaches it
  assign w_in_ready = r_in_ready & ~hlt;

  // stage FSM with skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PIPE_EMPTY;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= NOP_PC;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= NOP_PC;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_state      <= PIPE_EMPTY;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= NOP_PC;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= NOP_PC;
      r_in_ready   <= 1'b1;
    end else if (hlt) begin
      r_state      <= r_state;
      r_main_instr <= r_main_instr;
      r_main_pc    <= r_main_pc;
      r_skid_instr <= r_skid_instr;
      r_skid_pc    <= r_skid_pc;
      r_in_ready   <= r_in_ready;
    end else begin
      case (r_state)
        PIPE_EMPTY: begin
          if (w_accept) begin
            r_state      <= PIPE_FULL;
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
          end else begin
            r_state <= PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          if (w_accept && w_release) begin
            r_state      <= PIPE_FULL;
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
          end else if (w_accept) begin
            // downstream stalled: park the new word, drop ready next cycle
            r_state      <= PIPE_SKID;
            r_skid_instr <= in_instr;
            r_skid_pc    <= in_pc;
            r_in_ready   <= 1'b0;
          end else if (w_release) begin
            r_state      <= PIPE_EMPTY;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= NOP_PC;
          end else begin
            r_state <= PIPE_FULL;
          end
        end
        PIPE_SKID: begin
          if (w_release) begin
            r_state      <= PIPE_FULL;
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= NOP_PC;
            r_in_ready   <= 1'b1;
          end else begin
            r_state <= PIPE_SKID;
          end
        end
        default: begin
          r_state      <= PIPE_EMPTY;
          r_main_instr <= NOP_INSTR;
          r_main_pc    <= NOP_PC;
          r_skid_instr <= NOP_INSTR;
          r_skid_pc    <= NOP_PC;
          r_in_ready   <= 1'b1;
        end
      endcase
    end
  end
`else
  // without a skid entry, a full stage can only take a word it is also releasing
  assign w_in_ready = ~hlt & (~w_out_valid | out_ready);

  // stage FSM, single entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PIPE_EMPTY;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= NOP_PC;
    end else if (flush) begin
      r_state      <= PIPE_EMPTY;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= NOP_PC;
    end else if (hlt) begin
      r_state      <= r_state;
      r_main_instr <= r_main_instr;
      r_main_pc    <= r_main_pc;
    end else begin
      case (r_state)
        PIPE_EMPTY: begin
          if (w_accept) begin
            r_state      <= PIPE_FULL;
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
          end else begin
            r_state <= PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          if (w_accept) begin
            r_state      <= PIPE_FULL;
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
          end else if (w_release) begin
            r_state      <= PIPE_EMPTY;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= NOP_PC;
          end else begin
            r_state <= PIPE_FULL;
          end
        end
        default: begin
          r_state      <= PIPE_EMPTY;
          r_main_instr <= NOP_INSTR;
          r_main_pc    <= NOP_PC;
        end
      endcase
    end
  end
`endif

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall),
    .cnt   (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_instr = r_main_instr;
  assign out_pc    = r_main_pc;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random
// traffic, all checked against a queue-based occupancy model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hlt;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [21:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [21:0] out_pc;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [53:0] q[$];
  logic [21:0] rel_q[$];
  logic [21:0] src_q[$];
  int          cnt_m;
  bit          acc_d;

  pipe_stage_reg #(.INSTR_W(32), .PC_W(22), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ready_m();
    if (CAP == 2) return (q.size() < 2) && !hlt;
    else return !hlt && (q.size() == 0 || out_ready);
  endfunction

  // Called at a negedge with inputs set; checks outputs, then advances the model.
  task automatic cycle();
    bit ev, er, rel;
    logic [53:0] eh;
    #1;
    ev = (q.size() > 0) && !hlt;
    eh = (q.size() > 0) ? q[0] : 54'd0;
    er = ready_m();
    check("out_valid", out_valid, ev);
    check("out_pc", out_pc, eh[21:0]);
    check("out_instr", out_instr, eh[53:22]);
    check("in_ready", in_ready, er);
    check("stall_cnt", stall_cnt, cnt_m);
    @(posedge clk);
    if (ev && !out_ready) cnt_m = (cnt_m == 15) ? 15 : cnt_m + 1;
    acc_d = in_valid && er && !hlt && !flush;
    if (flush) begin
      q.delete();
    end else begin
      rel = ev && out_ready;
      if (rel) begin
        rel_q.push_back(q[0][21:0]);
        void'(q.pop_front());
      end
      if (acc_d) q.push_back({in_instr, in_pc});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hlt = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 22'd0;
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 22'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_stall_cnt", stall_cnt, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); rel_q.delete(); cnt_m = 0;
  endtask

  // Upstream presents src_q in order, holding each word until accepted.
  // mode 0: out_ready=1; 1: low on cycles 1..3; 2: toggles; 3: always low.
  task automatic feed(input int n_cycles, input int mode);
    int idx = 0;
    for (int c = 0; c < n_cycles; c++) begin
      in_valid = (idx < src_q.size());
      in_pc    = (idx < src_q.size()) ? src_q[idx] : 22'd0;
      in_instr = {10'h2A5, in_pc};
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = !(c >= 1 && c <= 3);
        2: out_ready = (c % 2 == 0);
        default: out_ready = 1'b0;
      endcase
      cycle();
      if (acc_d) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_n"}, rel_q.size(), src_q.size());
    for (int i = 0; i < src_q.size() && i < rel_q.size(); i++)
      check(tag, rel_q[i], src_q[i]);
  endtask

  initial begin
    do_reset();

    // stream, no back-pressure
    src_q = '{22'h100, 22'h101, 22'h102, 22'h103, 22'h104};
    feed(7, 0);
    check_seq("stream_seq");
    check("stream_cnt", stall_cnt, 4'd0);

    // back-pressure for three cycles
    do_reset();
    src_q = '{22'h10, 22'h11, 22'h12};
    feed(9, 1);
    check_seq("bp_seq");
    check("bp_cnt", stall_cnt, 4'd3);

    // flush with the stage holding words and a word on the input
    do_reset();
    src_q = '{22'h1, 22'h2};
    feed(3, 3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 22'h20; in_instr = 32'hDEAD0020;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_valid", out_valid, 1'b0);
    check("flush_pc", out_pc, 22'd0);
    check("flush_instr", out_instr, 32'd0);
    @(negedge clk);
    rel_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("flush_none_out", rel_q.size(), 0);

    // halt while full
    do_reset();
    src_q = '{22'h30};
    feed(1, 3);
    out_ready = 1'b1; hlt = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    hlt = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_seq("hlt_seq");
    check("hlt_cnt", stall_cnt, 4'd0);

    // saturation, then asynchronous reset mid-stream
    do_reset();
    src_q = '{22'h50, 22'h51, 22'h52};
    feed(21, 3);
    check("sat_cnt", stall_cnt, 4'd15);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_pc", out_pc, 22'd0);
    check("arst_instr", out_instr, 32'd0);
    check("arst_cnt", stall_cnt, 4'd0);
    check("arst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); rel_q.delete(); cnt_m = 0;

    // toggling out_ready, ordering preserved
    src_q = '{22'h40, 22'h41, 22'h42, 22'h43, 22'h44, 22'h45};
    feed(20, 2);
    check_seq("tog_seq");

    // random traffic including hlt and flush
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 3) != 0;
      hlt       = $urandom_range(0, 9) == 0;
      flush     = $urandom_range(0, 15) == 0;
      in_pc     = 22'($urandom);
      in_instr  = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-width IF/ID latch. It sits between any two CPU pipeline stages (IF/ID, ID/EX, …) and carries an instruction word plus PC. It uses a valid/ready handshake, so stalls propagate by back-pressure rather than a global stall wire. A compile-time skid entry breaks the combinational ready path; flush and halt keep the existing pipeline semantics (flush → NOP bubble, halt → freeze).

## Interface
- INSTR_W, 32, instruction word width
- PC_W, 22, PC width
- CNT_W, 16, stall-cycle counter width
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- hlt  input  1  freeze: no state change, no handshakes
- flush  input  1  kill all held entries; highest priority after reset
- in_valid  input  1  upstream has a word
- in_ready  output  1  stage can accept a word this cycle
- in_instr  input  INSTR_W  upstream instruction
- in_pc  input  PC_W  upstream PC
- out_valid  output  1  stage holds a word for downstream
- out_ready  input  1  downstream accepts this cycle
- out_instr  output  INSTR_W  held instruction; 0 (NOP) when empty
- out_pc  output  PC_W  held PC; 0 when empty
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles

## Operation
- Handshakes: accept when in_valid & in_ready & !hlt & !flush; release when out_valid & out_ready (out_valid is already masked by hlt).
- Storage: main register (drives outputs) plus, with skid enabled, one skid register.
- States: EMPTY (main empty), FULL (main holds a word), SKID (main and skid both hold words).
- EMPTY: accept → FULL.
- FULL:
  - accept with release → FULL, new word in main.
  - release only → EMPTY.
  - accept only → SKID, new word in skid.
- SKID: release → FULL, skid moves to main. in_ready = 0, so no accept is possible.
- Simultaneous accept and release in FULL is a pass-through: no bubble, no skid use.
- flush: next state EMPTY. main and skid instr/pc are set to 0, as is the valid flag. Any concurrent input is dropped, and a concurrent release does not complete.
- hlt (without flush): all state holds; in_ready = 0, out_valid = 0. out_instr/out_pc keep their values.
- stall_cnt: increments each cycle out_valid & !out_ready & !hlt; saturates at all-ones; cleared only by rst_n.
- Reset: state EMPTY; all data registers 0; stall_cnt 0.
  - Reset output values: out_valid 0, out_instr 0, out_pc 0, stall_cnt 0, in_ready 1 with skid (registered), 1 without skid (empty stage).
- Reset mid-operation: held words are discarded immediately (asynchronous); no partial transfer survives.

## Timing
- Latency: in→out 1 cycle; an accepted word is visible on out_* on the next edge.
- Throughput: one word per cycle while out_ready stays high.
- With skid: in_ready is a register output, = (state != SKID), with no path from out_ready. The first cycle of back-pressure is absorbed; upstream sees in_ready = 0 one cycle later.
- Without skid: in_ready = !hlt & (!out_valid | out_ready), combinational from out_ready.
- flush takes effect at the edge where it is sampled: out_valid = 0 and out_instr = 0 in the following cycle.
- in_ready is unaffected by flush in its own cycle (no combinational flush path). An upstream handshake on a flush cycle is void.

## Configuration
- PIPE_STAGE_SKID_EN defined: skid register and SKID state present; in_ready registered as above.
- Not defined: no skid register, no SKID state; in_ready combinational as above. Data behaviour is otherwise identical, with one bubble-free transfer per cycle.

## Structure
- Shared package pipe_pkg:
  - state enum PIPE_EMPTY/PIPE_FULL/PIPE_SKID.
  - NOP encoding constant (all zeros).
  - default width constants INSTR_W_DEF = 32, PC_W_DEF = 22.
- Sub-module: sat_counter (CNT_W, inc, saturating, async reset), instantiated for stall_cnt. Everything else is flat.

## Test plan
- Reset then stream: in_valid = 1, out_ready = 1, pc 0x000100..0x000104 over 5 cycles → out_pc follows one cycle later; no gaps; stall_cnt = 0.
- Back-pressure with skid: pc 0x10, 0x11, 0x12, then out_ready = 0 for 3 cycles.
  - 0x10 held on out; 0x11 captured in skid; in_ready falls the next cycle.
  - After out_ready = 1, out sequence is 0x10, 0x11, 0x12 with no loss or duplication; stall_cnt = 3.
- Flush in SKID state: flush = 1 with in_valid = 1, pc 0x20 → next cycle out_valid = 0, out_instr = 0, out_pc = 0; 0x20 never appears on out.
- hlt for 4 cycles while FULL with pc 0x30 → out_pc stays 0x30, out_valid = 0, in_ready = 0, stall_cnt unchanged; after hlt drops, 0x30 is released once.
- Saturation: CNT_W = 4, out_ready = 0 for 20 cycles with out_valid = 1 → stall_cnt = 15; asserting rst_n low mid-stream → all outputs at reset values immediately.
- Without PIPE_STAGE_SKID_EN: out_ready toggling 1/0 per cycle → in_ready tracks out_ready in the same cycle; ordering preserved.
